// File: rtl/rank_beep_gen_pkg.sv
// Shared definitions for the rank-change sound blocks: rank encoding,
// player state, default tone timing and counter sizing helpers.
package rank_beep_gen_pkg;

    // Rank encoding used on active_rank and internally
    localparam logic [1:0] RANK_NONE = 2'd0;
    localparam logic [1:0] RANK_1    = 2'd1;
    localparam logic [1:0] RANK_2    = 2'd2;
    localparam logic [1:0] RANK_3    = 2'd3;

    // Tone player state
    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_e;

    // Default timing at 100 MHz: 1 s tone, 1760 / 1319 / 880 Hz squares
    localparam int DEF_BEEP_CYCLES = 100_000_000;
    localparam int DEF_HALF_P1     = 28409;
    localparam int DEF_HALF_P2     = 37908;
    localparam int DEF_HALF_P3     = 56818;

    // Cycles after reset release during which toggles are ignored
    localparam int ARM_CYCLES = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Counter width for a terminal count of n-1; never narrower than 1 bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rank_beep_gen_sync.sv
// One input lane: 2-flop synchroniser, previous-value register and a
// registered toggle pulse. Pulses are suppressed until the block is armed.
module toggle_sync_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    input  logic arm_i,
    output logic evt_o
);

    logic s1_q, s2_q, prev_q, evt_q;

    // Synchronise, track previous value and register the toggle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
            evt_q  <= 1'b0;
        end else begin
            s1_q   <= sig_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            evt_q  <= arm_i & (s2_q ^ prev_q);
        end
    end

    assign evt_o = evt_q;

endmodule

// File: rtl/rank_beep_gen.sv
// Rank-change beeper: watches three toggle-style rank-change inputs and
// plays a fixed-length square tone whose pitch identifies the rank.
module rank_beep_gen
    import rank_beep_gen_pkg::*;
#(
    parameter int BEEP_CYCLES = DEF_BEEP_CYCLES,
    parameter int HALF_P1     = DEF_HALF_P1,
    parameter int HALF_P2     = DEF_HALF_P2,
    parameter int HALF_P3     = DEF_HALF_P3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       signal_sound_1,
    input  logic       signal_sound_2,
    input  logic       signal_sound_3,
    input  logic       mute,
    output logic       audio_out,
    output logic       amp_en,
    output logic       busy,
    output logic [1:0] active_rank
);

    localparam int DW = cnt_w(BEEP_CYCLES);
    localparam int TW = cnt_w(max3(HALF_P1, HALF_P2, HALF_P3));

    logic [2:0]    sig_vec;
    logic [2:0]    evt_vec;
    logic [1:0]    arm_q, arm_d;
    logic          armed;
    logic          evt_any;
    logic [1:0]    evt_rank;

    state_e        state_q, state_d;
    logic [DW-1:0] dur_q, dur_d;
    logic [TW-1:0] tone_q, tone_d;
    logic          phase_q, phase_d;
    logic [1:0]    rank_q, rank_d;

    assign sig_vec = {signal_sound_3, signal_sound_2, signal_sound_1};

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_sync
            toggle_sync_detect u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .sig_i (sig_vec[g]),
                .arm_i (armed),
                .evt_o (evt_vec[g])
            );
        end
    endgenerate

    // Half-period reload value for a given rank
    function automatic logic [TW-1:0] half_m1(input logic [1:0] r);
        case (r)
            RANK_1:  return TW'(HALF_P1 - 1);
            RANK_2:  return TW'(HALF_P2 - 1);
            default: return TW'(HALF_P3 - 1);
        endcase
    endfunction

    // Arm counter saturates once the synchronisers have settled after reset
    always_comb begin
        armed = (arm_q == 2'(ARM_CYCLES));
        arm_d = armed ? arm_q : arm_q + 2'd1;
    end

    // Arm counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) arm_q <= 2'd0;
        else        arm_q <= arm_d;
    end

    // Lowest rank number wins; losing simultaneous events are dropped
    always_comb begin
        evt_any  = |evt_vec;
        evt_rank = RANK_NONE;
        if      (evt_vec[0]) evt_rank = RANK_1;
        else if (evt_vec[1]) evt_rank = RANK_2;
        else if (evt_vec[2]) evt_rank = RANK_3;
    end

    // Next state: any event (re)starts a tone, otherwise run the counters
    always_comb begin
        state_d = state_q;
        dur_d   = dur_q;
        tone_d  = tone_q;
        phase_d = phase_q;
        rank_d  = rank_q;
        if (evt_any) begin
            state_d = PLAY;
            dur_d   = DW'(BEEP_CYCLES - 1);
            tone_d  = half_m1(evt_rank);
            phase_d = 1'b1;
            rank_d  = evt_rank;
        end else if (state_q == PLAY) begin
            if (tone_q == '0) begin
                phase_d = ~phase_q;
                tone_d  = half_m1(rank_q);
            end else begin
                tone_d  = tone_q - TW'(1);
            end
            if (dur_q == '0) begin
                state_d = IDLE;
                phase_d = 1'b0;
                tone_d  = '0;
                rank_d  = RANK_NONE;
            end else begin
                dur_d   = dur_q - DW'(1);
            end
        end
    end

    // Player state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dur_q   <= '0;
            tone_q  <= '0;
            phase_q <= 1'b0;
            rank_q  <= RANK_NONE;
        end else begin
            state_q <= state_d;
            dur_q   <= dur_d;
            tone_q  <= tone_d;
            phase_q <= phase_d;
            rank_q  <= rank_d;
        end
    end

    // Outputs come straight from state so reset clears them at once;
    // mute only gates the pin, not the timing
    always_comb begin
        busy        = (state_q == PLAY);
        amp_en      = busy;
        active_rank = rank_q;
        audio_out   = phase_q & busy & ~mute;
    end

endmodule

// File: tb/tb_rank_beep_gen.sv
// Directed bench for rank_beep_gen with a per-cycle expectation queue.
module tb_rank_beep_gen;

    localparam int BC = 20;
    localparam int H1 = 2;
    localparam int H2 = 3;
    localparam int H3 = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
    logic       mute = 1'b0;
    logic       audio, amp, busy;
    logic [1:0] rank;

    // Expected {busy, amp_en, active_rank, audio_out} per sampled cycle
    logic [4:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rank_beep_gen #(
        .BEEP_CYCLES (BC),
        .HALF_P1     (H1),
        .HALF_P2     (H2),
        .HALF_P3     (H3)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .signal_sound_1 (s1),
        .signal_sound_2 (s2),
        .signal_sound_3 (s3),
        .mute           (mute),
        .audio_out      (audio),
        .amp_en         (amp),
        .busy           (busy),
        .active_rank    (rank)
    );

    function automatic int half_of(input int r);
        return (r == 1) ? H1 : (r == 2) ? H2 : H3;
    endfunction

    task automatic push_idle(input int n);
        repeat (n) exp_q.push_back(5'b0);
    endtask

    // Tone of len cycles for rank r; audio forced low before index unmute_at
    task automatic push_beep(input int r, input int len, input int unmute_at);
        logic aud;
        for (int k = 0; k < len; k++) begin
            aud = (((k / half_of(r)) % 2) == 0) && (k >= unmute_at);
            exp_q.push_back({1'b1, 1'b1, 2'(r), aud});
        end
    endtask

    task automatic cmp(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: busy/amp/rank/audio got=%b want=%b", tag, obs, exp);
        end
    endtask

    // Advance n cycles, checking each against the next queued expectation
    task automatic run(input int n, input string tag);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s: expectation queue empty, got=%b", tag, {busy, amp, rank, audio});
            end else begin
                cmp(tag, {busy, amp, rank, audio}, exp_q.pop_front());
            end
        end
    endtask

    task automatic run_all(input string tag);
        while (exp_q.size() > 0) run(1, tag);
    endtask

    initial begin
        // Reset with all inputs high; nothing must play after release
        s1 = 1'b1; s2 = 1'b1; s3 = 1'b1;
        @(negedge clk);
        cmp("reset_state", {busy, amp, rank, audio}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;
        push_idle(50);
        run_all("no_spurious");

        // Single rank-2 toggle
        s2 = ~s2;
        push_idle(3); push_beep(2, BC, 0); push_idle(5);
        run_all("rank2");

        // Ranks 1 and 3 together: rank 1 wins
        s1 = ~s1; s3 = ~s3;
        push_idle(3); push_beep(1, BC, 0); push_idle(5);
        run_all("prio_r1");

        // Rank 3 restarted by rank 2 ten cycles into the tone
        s3 = ~s3;
        push_idle(3); push_beep(3, 10, 0); push_beep(2, BC, 0); push_idle(5);
        run(10, "r3_before");
        s2 = ~s2;
        run_all("restart_r2");

        // Muted rank-1 beep, mute released mid-tone
        mute = 1'b1;
        s1 = ~s1;
        push_idle(3); push_beep(1, BC, 9); push_idle(5);
        run(12, "muted");
        mute = 1'b0;
        run_all("unmuted");

        // Reset during a tone
        s1 = ~s1;
        push_idle(3); push_beep(1, BC, 0);
        run(10, "pre_reset");
        rst_n = 1'b0;
        #1;
        cmp("async_reset", {busy, amp, rank, audio}, 5'b0);
        exp_q.delete();
        s1 = 1'b1; s2 = 1'b1; s3 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        push_idle(30);
        run_all("rearm_quiet");
        s2 = ~s2;
        push_idle(3); push_beep(2, BC, 0); push_idle(3);
        run_all("post_reset_beep");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
